// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, funct3
// encodings, status bit positions, trap cause codes and the
// read-modify-write helper.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // funct3 encodings; bit 2 selects the immediate form, bits [1:0] the operation
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // mstatus / mie / mip bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIP_MTIP     = 7;

    // mcause codes
    localparam logic [31:0] MCAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [31:0] MCAUSE_ECALL_M      = 32'd11;
    localparam logic [31:0] MCAUSE_M_TIMER_IRQ  = 32'h8000_0007;

    // Value a CSR instruction would leave in the register, given its old value
    function automatic logic [31:0] apply_op(input logic [2:0]  f3,
                                             input logic [31:0] old,
                                             input logic [31:0] d);
        case (f3[1:0])
            2'b01:   return d;
            2'b10:   return old | d;
            2'b11:   return old & ~d;
            default: return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// A write to one half wins over that half's increment; the other half keeps
// its own incremented value but sees no carry out of the overwritten half.
module csr_counter64 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;
    logic [63:0] w_inc;
    logic [63:0] w_next;

    assign w_inc   = r_count + {63'd0, i_inc};
    assign o_count = r_count;

    // Merge software half-writes over the incremented value
    always_comb begin
        w_next = w_inc;
        if (i_wr_lo) begin
            w_next[31:0]  = i_wdata;
            w_next[63:32] = r_count[63:32];
        end
        if (i_wr_hi) begin
            w_next[63:32] = i_wdata;
        end
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_count <= 64'd0;
        else         r_count <= w_next;
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core. Reads are combinational and
// return the pre-edge value; writes, trap entry and MRET commit on the edge.
// Same-edge priority: trap entry, then MRET, then the CSR instruction.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_we,
    input  logic        csr_re,
    input  logic [2:0]  csr_funct3,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_data_i,
    output logic [31:0] csr_data_o,
    output logic        csr_illegal,
    input  logic        instret_inc,
    input  logic        mtip,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_pending
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [63:0] w_cycle;
    logic [63:0] w_instret;
    logic [31:0] w_old;
    logic [31:0] w_new;
    logic        w_supported;
    logic        w_bad_f3;
    logic        w_eff_wr;
    logic        w_wr;

    // Old-value read mux and address decode
    always_comb begin
        w_supported = 1'b1;
        w_old       = 32'd0;
        case (csr_addr)
            CSR_MSTATUS: begin
                w_old[MSTATUS_MIE]  = r_mstatus_mie;
                w_old[MSTATUS_MPIE] = r_mstatus_mpie;
            end
            CSR_MISA:                    w_old = MISA_VAL;
            CSR_MIE:                     w_old = r_mie;
            CSR_MTVEC:                   w_old = r_mtvec;
            CSR_MSCRATCH:                w_old = r_mscratch;
            CSR_MEPC:                    w_old = r_mepc;
            CSR_MCAUSE:                  w_old = r_mcause;
            CSR_MTVAL:                   w_old = r_mtval;
            CSR_MIP:                     w_old[MIP_MTIP] = mtip;
            CSR_MCYCLE,    CSR_CYCLE:    w_old = w_cycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   w_old = w_cycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  w_old = w_instret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_old = w_instret[63:32];
            CSR_MHARTID:                 w_old = HART_ID;
            default:                     w_supported = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it never counts as a write
    assign w_bad_f3    = (csr_funct3[1:0] == 2'b00);
    assign w_eff_wr    = csr_we && !w_bad_f3 && ((csr_funct3[1:0] == 2'b01) || (csr_data_i != 32'd0));
    assign csr_illegal = (csr_we || csr_re) &&
                         (!w_supported || w_bad_f3 || (w_eff_wr && (csr_addr[11:10] == 2'b11)));
    assign w_wr        = w_eff_wr && !csr_illegal;
    assign w_new       = apply_op(csr_funct3, w_old, csr_data_i);

    assign csr_data_o  = csr_re ? w_old : 32'd0;
    assign mtvec_o     = r_mtvec;
    assign mepc_o      = r_mepc;
    assign irq_pending = r_mstatus_mie && r_mie[MIE_MTIE] && mtip;

    csr_counter64 u_mcycle (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr && (csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_wr && (csr_addr == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_count (w_cycle)
    );

    csr_counter64 u_minstret (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (instret_inc),
        .i_wr_lo (w_wr && (csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_wr && (csr_addr == CSR_MINSTRETH)),
        .i_wdata (w_new),
        .o_count (w_instret)
    );

    // Trap state and plain CSRs; trap/mret suppress writes to the registers they own
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mtvec        <= RESET_MTVEC;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
        end else begin
            if (trap_valid) begin
                r_mepc         <= trap_pc & ~32'd3;
                r_mcause       <= trap_cause;
                r_mtval        <= trap_tval;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (mret) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end else if (w_wr && (csr_addr == CSR_MSTATUS)) begin
                    r_mstatus_mie  <= w_new[MSTATUS_MIE];
                    r_mstatus_mpie <= w_new[MSTATUS_MPIE];
                end
                if (w_wr && (csr_addr == CSR_MEPC))   r_mepc   <= w_new & ~32'd3;
                if (w_wr && (csr_addr == CSR_MCAUSE)) r_mcause <= w_new;
                if (w_wr && (csr_addr == CSR_MTVAL))  r_mtval  <= w_new;
            end
            if (w_wr && (csr_addr == CSR_MIE))      r_mie      <= w_new;
            if (w_wr && (csr_addr == CSR_MTVEC))    r_mtvec    <= w_new & ~32'd3;
            if (w_wr && (csr_addr == CSR_MSCRATCH)) r_mscratch <= w_new;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_csr_file;

    localparam logic [31:0] P_HART  = 32'd5;
    localparam logic [31:0] P_MTVEC = 32'h0000_1000;
    localparam logic [31:0] P_MISA  = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_we = 1'b0, csr_re = 1'b0;
    logic [2:0]  csr_funct3 = 3'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_data_i = 32'd0;
    logic [31:0] csr_data_o;
    logic        csr_illegal;
    logic        instret_inc = 1'b0, mtip = 1'b0, trap_valid = 1'b0, mret = 1'b0;
    logic [31:0] trap_cause = 32'd0, trap_pc = 32'd0, trap_tval = 32'd0;
    logic [31:0] mtvec_o, mepc_o;
    logic        irq_pending;

    int n_checks = 0;
    int n_fail   = 0;

    csr_file #(.HART_ID(P_HART), .RESET_MTVEC(P_MTVEC), .MISA_VAL(P_MISA)) dut (
        .clk(clk), .reset(reset), .csr_we(csr_we), .csr_re(csr_re),
        .csr_funct3(csr_funct3), .csr_addr(csr_addr), .csr_data_i(csr_data_i),
        .csr_data_o(csr_data_o), .csr_illegal(csr_illegal), .instret_inc(instret_inc),
        .mtip(mtip), .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o),
        .irq_pending(irq_pending)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    function automatic logic [31:0] m_read(input logic [11:0] a, output logic ok);
        ok = 1'b1;
        case (a)
            12'h300: return m_mstatus;
            12'h301: return P_MISA;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return mtip ? 32'h80 : 32'h0;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            12'hF14: return P_HART;
            default: begin ok = 1'b0; return 32'h0; end
        endcase
    endfunction

    // Is the current request a real write, and is it illegal
    task automatic m_access(output logic eff, output logic ill, output logic [31:0] nv);
        logic ok;
        logic [31:0] old;
        logic [1:0] kind;
        old  = m_read(csr_addr, ok);
        kind = csr_funct3[1:0];
        eff  = csr_we && (kind != 2'd0) && (kind == 2'd1 || csr_data_i != 0);
        ill  = (csr_we || csr_re) && (!ok || kind == 2'd0 || (eff && csr_addr >= 12'hC00));
        nv   = (kind == 2'd1) ? csr_data_i : (kind == 2'd2) ? (old | csr_data_i) : (old & ~csr_data_i);
    endtask

    // Model state update on every rising edge
    always @(posedge clk) begin
        logic eff, ill;
        logic [31:0] nv;
        logic [63:0] n_cyc, n_ins;
        if (reset) begin
            m_mstatus = 0; m_mie = 0; m_mtvec = P_MTVEC; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_access(eff, ill, nv);
            n_cyc = m_cycle + 64'd1;
            n_ins = m_instret + (instret_inc ? 64'd1 : 64'd0);
            if (eff && !ill) begin
                case (csr_addr)
                    12'h300: if (!trap_valid && !mret) m_mstatus = nv & 32'h88;
                    12'h304: m_mie = nv;
                    12'h305: m_mtvec = nv & ~32'd3;
                    12'h340: m_mscratch = nv;
                    12'h341: if (!trap_valid) m_mepc = nv & ~32'd3;
                    12'h342: if (!trap_valid) m_mcause = nv;
                    12'h343: if (!trap_valid) m_mtval = nv;
                    12'hB00: n_cyc = {m_cycle[63:32], nv};
                    12'hB80: n_cyc = {nv, n_cyc[31:0]};
                    12'hB02: n_ins = {m_instret[63:32], nv};
                    12'hB82: n_ins = {nv, n_ins[31:0]};
                    default: ;
                endcase
            end
            if (trap_valid) begin
                m_mepc = trap_pc & ~32'd3; m_mcause = trap_cause; m_mtval = trap_tval;
                m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            end else if (mret) begin
                m_mstatus = m_mstatus[7] ? 32'h88 : 32'h80;
            end
            m_cycle = n_cyc;
            m_instret = n_ins;
        end
    end

    // Compare every output against the model away from the active edge
    always @(negedge clk) begin
        logic eff, ill, ok;
        logic [31:0] nv, rv;
        if (m_valid) begin
            m_access(eff, ill, nv);
            rv = m_read(csr_addr, ok);
            chk("cmp_data", csr_data_o, csr_re ? rv : 32'h0);
            chk("cmp_illegal", csr_illegal, ill);
            chk("cmp_mtvec", mtvec_o, m_mtvec);
            chk("cmp_mepc", mepc_o, m_mepc);
            chk("cmp_irq", irq_pending, m_mstatus[3] & m_mie[7] & mtip);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                      input logic chk_old, input logic [31:0] exp_old, input logic exp_ill, input string name);
        csr_we = we; csr_re = 1'b1; csr_funct3 = f3; csr_addr = a; csr_data_i = d;
        #1;
        if (chk_old) chk({name, "_old"}, csr_data_o, exp_old);
        chk({name, "_ill"}, csr_illegal, exp_ill);
        cyc();
        csr_we = 0; csr_re = 0; csr_funct3 = 0; csr_addr = 0; csr_data_i = 0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        op(1'b0, 3'b010, a, 32'h0, 1'b1, exp, 1'b0, name);
    endtask

    // ---------------- stimulus ----------------
    logic [11:0] addr_tab [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                     12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                     12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14,
                                     12'h7C0, 12'h306, 12'hF15, 12'h300};

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (10) cyc();
        chk("rst_mtvec", mtvec_o, P_MTVEC);
        chk("rst_mepc", mepc_o, 32'h0);
        chk("rst_irq", irq_pending, 1'b0);
        #1 chk("idle_data", csr_data_o, 32'h0);
        chk("idle_ill", csr_illegal, 1'b0);
        #1;
        rd(12'hB00, 32'd10, "mcycle10");
        rd(12'hB80, 32'd0, "mcycleh0");
        instret_inc = 1'b1;
        repeat (3) cyc();
        instret_inc = 1'b0;
        rd(12'hB02, 32'd3, "minstret3");

        op(1, 3'b001, 12'h340, 32'hDEAD_BEEF, 1, 32'h0, 0, "scr_rw");
        op(1, 3'b010, 12'h340, 32'h0000_00F0, 1, 32'hDEAD_BEEF, 0, "scr_rs");
        op(1, 3'b011, 12'h340, 32'hDEAD_0000, 1, 32'hDEAD_BEFF, 0, "scr_rc");
        rd(12'h340, 32'h0000_BEFF, "scr_final");

        op(1, 3'b001, 12'hB00, 32'hFFFF_FFFE, 0, 32'h0, 0, "cyc_lo");
        op(1, 3'b001, 12'hB80, 32'hFFFF_FFFF, 1, 32'h0, 0, "cyc_hi");
        rd(12'hB00, 32'hFFFF_FFFF, "cyc_max");
        rd(12'hB80, 32'h0, "cyc_wrap_hi");
        rd(12'hB00, 32'h1, "cyc_wrap_lo");

        op(1, 3'b110, 12'h300, 32'd8, 1, 32'h0, 0, "mie_set");
        trap_valid = 1; trap_pc = 32'h106; trap_cause = 32'd11; trap_tval = 32'h55;
        cyc();
        trap_valid = 0;
        chk("trap_mepc_o", mepc_o, 32'h104);
        rd(12'h342, 32'd11, "trap_mcause");
        rd(12'h343, 32'h55, "trap_mtval");
        rd(12'h300, 32'h80, "trap_mstatus");
        mret = 1; cyc(); mret = 0;
        rd(12'h300, 32'h88, "mret_mstatus");

        op(1, 3'b001, 12'hC00, 32'd5, 0, 32'h0, 1, "ro_write");
        op(1, 3'b010, 12'hC00, 32'd0, 0, 32'h0, 0, "ro_rs0");
        op(0, 3'b010, 12'h7C0, 32'd0, 1, 32'h0, 1, "bad_addr");
        op(1, 3'b000, 12'h340, 32'd1, 0, 32'h0, 1, "bad_f3");
        op(1, 3'b001, 12'hF14, 32'd1, 1, P_HART, 1, "hartid_wr");
        op(1, 3'b001, 12'h301, 32'd0, 1, P_MISA, 0, "misa_wr");
        rd(12'h301, P_MISA, "misa_keep");
        op(1, 3'b101, 12'h344, 32'd31, 1, 32'h0, 0, "mip_wr");

        trap_valid = 1; trap_pc = 32'h20B; trap_cause = 32'd2;
        op(1, 3'b001, 12'h341, 32'h500, 1, 32'h104, 0, "mepc_race");
        trap_valid = 0;
        rd(12'h341, 32'h208, "mepc_trap_wins");

        op(1, 3'b110, 12'h304, 32'h80, 1, 32'h0, 0, "mtie_set");
        op(1, 3'b110, 12'h300, 32'h8, 1, 32'h80, 0, "mie_set2");
        mtip = 1;
        rd(12'h344, 32'h80, "mip_img");
        chk("irq_on", irq_pending, 1'b1);
        mtip = 0;
        op(1, 3'b001, 12'h305, 32'h0000_2003, 1, P_MTVEC, 0, "mtvec_wr");
        chk("mtvec_align", mtvec_o, 32'h2000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            csr_we      = $urandom_range(0, 1);
            csr_re      = $urandom_range(0, 1);
            csr_funct3  = 3'($urandom_range(0, 7));
            csr_addr    = addr_tab[$urandom_range(0, 21)];
            csr_data_i  = $urandom;
            if (csr_funct3[2]) csr_data_i = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) csr_data_i = 32'h0;
            if ($urandom_range(0, 15) == 0) csr_data_i = 32'hFFFF_FFFF;
            instret_inc = $urandom_range(0, 1);
            mtip        = $urandom_range(0, 1);
            trap_valid  = ($urandom_range(0, 19) == 0);
            mret        = ($urandom_range(0, 19) == 0);
            trap_pc     = $urandom;
            trap_cause  = $urandom;
            trap_tval   = $urandom;
            cyc();
        end
        reset = 0; csr_we = 0; csr_re = 0; trap_valid = 0; mret = 0; instret_inc = 0;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode Control and Status Register file for the RV32I core.
- Sits beside the execute stage: consumes the core's csr_we/csr_re/csr_funct3/csr_addr/csr_data_i.
- Returns the old CSR value for rd writeback.
- Holds trap state (mstatus/mepc/mcause/mtval/mtvec) and the 64-bit cycle and instret counters.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset.
- MISA_VAL, 32'h4000_0100, constant returned by misa (RV32I).

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- csr_we  input  1  CSR write request from decode.
- csr_re  input  1  CSR read request from decode.
- csr_funct3  input  3  instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- csr_addr  input  12  CSR address.
- csr_data_i  input  32  rs1 value, or zero-extended zimm for the I forms.
- csr_data_o  output  32  old CSR value, combinational; 0 when csr_re=0.
- csr_illegal  output  1  combinational illegal-access flag.
- instret_inc  input  1  one-cycle pulse per retired instruction.
- mtip  input  1  machine timer interrupt pending level.
- trap_valid  input  1  one-cycle trap-entry pulse.
- trap_cause  input  32  mcause value for the trap.
- trap_pc  input  32  PC of the trapping instruction.
- trap_tval  input  32  mtval value.
- mret  input  1  one-cycle MRET pulse.
- mtvec_o  output  32  current mtvec.
- mepc_o  output  32  current mepc.
- irq_pending  output  1  mstatus.MIE & mie.MTIE(bit7) & mtip.

Behaviour:
- Read: csr_data_o reflects the register state before the current edge, with zero added latency.
- Write: new = RW: d; RS: old|d; RC: old&~d. The result commits at the next rising edge.
- RS/RC/RSI/RCI with d==0 are not writes: no state change and no illegal-on-read-only.
- Supported addresses:
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; other bits read 0.
  - misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - mip 0x344: read-only image with bit7 = mtip; writes are ignored, not illegal.
  - mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - cycle 0xC00, instret 0xC02, cycleh 0xC80, instreth 0xC82: read-only aliases.
  - mhartid 0xF14: read-only.
  - misa writes are ignored, not illegal.
- csr_illegal=1 when (csr_we|csr_re) and any of:
  - unsupported address;
  - funct3 is 000 or 100;
  - effective write to addr[11:10]==2'b11.
- An illegal access changes no state. The core raises the trap itself.
- mtvec and mepc bits[1:0] are forced to 0 on every write path (direct mode only).
- Counters: mcycle is 64-bit and increments every cycle. minstret increments when instret_inc=1.
  - Carry propagates from low to high; 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A software write to a half takes priority over that cycle's increment for that half.
  - The other half keeps its incremented value with no carry from the overwritten half.
- Trap entry (trap_valid):
  - mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval.
  - MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority on the same edge: trap_valid > mret > CSR write.
  - A lower-priority write to a register the higher event touches is dropped.
  - Writes to untouched registers still commit.
- Counters keep counting through trap and mret.
- Reset: every register is 0 except mtvec=RESET_MTVEC. Consequences:
  - csr_data_o=0 and csr_illegal=0 with no request; irq_pending=0; mepc_o=0; mtvec_o=RESET_MTVEC.
  - Reset asserted mid-operation overrides all pending writes, traps and increments on that edge.
  - Counters read 0 on the first cycle after reset deasserts.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams;
  - funct3 encodings;
  - mstatus bit indices (MIE=3, MPIE=7) and mie/mip MTIE/MTIP index 7;
  - mcause codes (illegal instruction 2, ecall 11, timer interrupt 0x8000_0007).
- One sub-module, csr_counter64:
  - inputs: inc, wr_lo, wr_hi, wdata;
  - output: 64-bit count;
  - instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then idle 10 cycles -> a read of mcycle (0xB00) returns 10 ±0 per the exact cycle count after reset deasserts; mcycleh=0; mtvec_o=RESET_MTVEC.
- CSRRW mscratch with 0xDEAD_BEEF, then CSRRS with 0x0000_00F0, then CSRRC with 0xDEAD_0000 -> reads return 0, 0xDEAD_BEEF, 0xDEAD_BEFF; final value 0x0000_BEFF.
- Write mcycle=0xFFFF_FFFE and mcycleh=0xFFFF_FFFF, then wait 2 cycles -> count wraps, mcycleh=0, mcycle=0 or 1 per cycle.
- Set mstatus.MIE=1, then trap_valid with pc=0x0000_0106 and cause=11 -> mepc=0x104, mcause=11, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- CSRRW to cycle (0xC00) -> csr_illegal=1 and no state change. CSRRS to 0xC00 with d=0 -> csr_illegal=0. Read of 0x7C0 -> csr_illegal=1.
- trap_valid and a CSRRW to mepc with 0x500 on the same edge -> mepc = trap_pc&~3. Separately, mie.MTIE=1, MIE=1, mtip=1 -> irq_pending=1.
